// File: rtl/esfa_op_sequencer_if.sv
// Host command, cell broadcast, reduction-tree and response signals of the ESFA sequencer.
// The sequencer takes the master modport; the host/array environment takes the slave modport.
interface esfa_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_handle;
    logic [7:0] cmd_index;
    logic [7:0] cmd_value;
    logic [7:0] cmd_metadata;
    logic       cmd_is_metadata;

    logic [7:0] cell_selector;
    logic       cell_will_write;
    logic [7:0] cell_handle;
    logic [7:0] cell_index;
    logic [7:0] cell_value;
    logic [7:0] cell_metadata;
    logic       cell_is_metadata;

    logic       red_bool;
    logic [7:0] red_value;
    logic [7:0] red_context;

    logic       resp_valid;
    logic       resp_ready;
    logic [1:0] resp_status;
    logic [7:0] resp_value;
    logic [7:0] resp_context;

    modport master (
        input  cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_metadata,
               cmd_is_metadata, red_bool, red_value, red_context, resp_ready,
        output cmd_ready, cell_selector, cell_will_write, cell_handle, cell_index,
               cell_value, cell_metadata, cell_is_metadata,
               resp_valid, resp_status, resp_value, resp_context
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_metadata,
               cmd_is_metadata, red_bool, red_value, red_context, resp_ready,
        input  cmd_ready, cell_selector, cell_will_write, cell_handle, cell_index,
               cell_value, cell_metadata, cell_is_metadata,
               resp_valid, resp_status, resp_value, resp_context
    );
endinterface

// File: rtl/esfa_op_sequencer.sv
// Splits one host operation into 1-3 broadcast/reduce phases over the ESFA cell array
// and returns a single response per command.
module esfa_op_sequencer #(
    parameter int unsigned RED_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    esfa_op_sequencer_if.master  bus,
    output logic                 busy
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP} state_e;

    localparam logic [1:0] OP_LOOKUP  = 2'd0;
    localparam logic [1:0] OP_UPDATE  = 2'd1;
    localparam logic [1:0] OP_ENCODE  = 2'd2;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FULL    = 2'b01;
    localparam logic [1:0] ST_MISS    = 2'b10;
    localparam logic [1:0] ST_BADOP   = 2'b11;
    localparam logic [7:0] SEL_SCAN   = 8'h01;
    localparam logic [2:0] WAIT_LAST  = (RED_LAT > 0) ? 3'(RED_LAT - 1) : 3'd0;

    function automatic logic [7:0] phase_sel(input logic [1:0] op, input logic [1:0] ph);
        logic [7:0] sel;
        sel = 8'h01;
        unique case (op)
            OP_LOOKUP: sel = (ph == 2'd0) ? 8'h01 : 8'h07;
            OP_UPDATE: sel = (ph == 2'd0) ? 8'h05 : ((ph == 2'd1) ? 8'h00 : 8'h06);
            OP_ENCODE: sel = 8'h02;
            default:   sel = (ph == 2'd0) ? 8'h03 : 8'h04;
        endcase
        return sel;
    endfunction

    function automatic logic phase_wr(input logic [1:0] op, input logic [1:0] ph);
        return ((op == OP_UPDATE) && (ph == 2'd1)) || (op == 2'd3);
    endfunction

    function automatic logic [1:0] last_phase(input logic [1:0] op);
        logic [1:0] lp;
        unique case (op)
            OP_LOOKUP: lp = 2'd1;
            OP_UPDATE: lp = 2'd2;
            OP_ENCODE: lp = 2'd0;
            default:   lp = 2'd1;
        endcase
        return lp;
    endfunction

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] wait_q, wait_d;
    logic [1:0] op_q, op_d;
    logic [7:0] handle_q, handle_d, index_q, index_d, value_q, value_d, meta_q, meta_d;
    logic       is_meta_q, is_meta_d;
    logic [1:0] status_q, status_d;
    logic [7:0] rvalue_q, rvalue_d, rctx_q, rctx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            wait_q    <= 3'd0;
            op_q      <= 2'd0;
            handle_q  <= 8'd0;
            index_q   <= 8'd0;
            value_q   <= 8'd0;
            meta_q    <= 8'd0;
            is_meta_q <= 1'b0;
            status_q  <= ST_OK;
            rvalue_q  <= 8'd0;
            rctx_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            handle_q  <= handle_d;
            index_q   <= index_d;
            value_q   <= value_d;
            meta_q    <= meta_d;
            is_meta_q <= is_meta_d;
            status_q  <= status_d;
            rvalue_q  <= rvalue_d;
            rctx_q    <= rctx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wait_d    = wait_q;
        op_d      = op_q;
        handle_d  = handle_q;
        index_d   = index_q;
        value_d   = value_q;
        meta_d    = meta_q;
        is_meta_d = is_meta_q;
        status_d  = status_q;
        rvalue_d  = rvalue_q;
        rctx_d    = rctx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op[2]) begin
                        status_d = ST_BADOP;
                        rvalue_d = 8'd0;
                        rctx_d   = 8'd0;
                        state_d  = S_RESP;
                    end else begin
                        op_d      = bus.cmd_op[1:0];
                        handle_d  = bus.cmd_handle;
                        index_d   = bus.cmd_index;
                        value_d   = bus.cmd_value;
                        meta_d    = bus.cmd_metadata;
                        is_meta_d = bus.cmd_is_metadata;
                        phase_d   = 2'd0;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (RED_LAT == 0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d  = WAIT_LAST;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == 3'd0) state_d = S_CAPTURE;
                else                wait_d  = wait_q - 3'd1;
            end
            S_CAPTURE: begin
                rvalue_d = bus.red_value;
                rctx_d   = bus.red_context;
                status_d = ST_OK;
                // Phase 0 of LOOKUP/UPDATE locates the target cell; its context feeds phase 1.
                if ((phase_q == 2'd0) && ((op_q == OP_LOOKUP) || (op_q == OP_UPDATE)) && !bus.red_bool) begin
                    state_d = S_RESP;
                    if (op_q == OP_LOOKUP) begin
                        status_d = ST_MISS;
                        rvalue_d = 8'd0;
                        rctx_d   = 8'd0;
                    end else begin
                        status_d = ST_FULL;
                    end
                end else begin
                    if ((phase_q == 2'd0) && ((op_q == OP_LOOKUP) || (op_q == OP_UPDATE)))
                        meta_d = bus.red_context;
                    if (phase_q == last_phase(op_q)) begin
                        state_d = S_RESP;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready        = (state_q == S_IDLE);
    assign busy                 = (state_q != S_IDLE);
    assign bus.cell_selector    = (state_q == S_ISSUE) ? phase_sel(op_q, phase_q) : SEL_SCAN;
    assign bus.cell_will_write  = (state_q == S_ISSUE) && phase_wr(op_q, phase_q);
    assign bus.cell_handle      = handle_q;
    assign bus.cell_index       = index_q;
    assign bus.cell_value       = value_q;
    assign bus.cell_metadata    = meta_q;
    assign bus.cell_is_metadata = is_meta_q;
    assign bus.resp_valid       = (state_q == S_RESP);
    assign bus.resp_status      = status_q;
    assign bus.resp_value       = rvalue_q;
    assign bus.resp_context     = rctx_q;
endmodule

// File: tb/tb_esfa_op_sequencer.sv
// Directed bench for esfa_op_sequencer: one instance with RED_LAT=0 and one with RED_LAT=2,
// stepped cycle by cycle with hand-computed expectations.
module tb_esfa_op_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic busy0, busy2;
    int   total = 0;
    int   bad = 0;
    int   wr_cnt, wr_cyc;
    logic wr_seen;

    esfa_op_sequencer_if if0();
    esfa_op_sequencer_if if2();

    esfa_op_sequencer #(.RED_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0));
    esfa_op_sequencer #(.RED_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .busy(busy2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if0.cmd_valid = 1'b0; if0.cmd_op = 3'd0; if0.cmd_handle = 8'd0; if0.cmd_index = 8'd0;
        if0.cmd_value = 8'd0; if0.cmd_metadata = 8'd0; if0.cmd_is_metadata = 1'b0;
        if0.red_bool = 1'b0; if0.red_value = 8'd0; if0.red_context = 8'd0; if0.resp_ready = 1'b1;
        if2.cmd_valid = 1'b0; if2.cmd_op = 3'd0; if2.cmd_handle = 8'd0; if2.cmd_index = 8'd0;
        if2.cmd_value = 8'd0; if2.cmd_metadata = 8'd0; if2.cmd_is_metadata = 1'b0;
        if2.red_bool = 1'b0; if2.red_value = 8'd0; if2.red_context = 8'd0; if2.resp_ready = 1'b1;
    endtask

    task automatic set_red0(input logic b, input logic [7:0] v, input logic [7:0] c);
        if0.red_bool = b; if0.red_value = v; if0.red_context = c;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready",  8'(if0.cmd_ready), 8'd1);
        chk("rst_resp_valid", 8'(if0.resp_valid), 8'd0);
        chk("rst_selector",   if0.cell_selector, 8'h01);
        chk("rst_will_write", 8'(if0.cell_will_write), 8'd0);
        chk("rst_busy",       8'(busy0), 8'd0);
        chk("rst_status",     8'(if0.resp_status), 8'd0);
        chk("rst_resp_value", if0.resp_value, 8'd0);
        chk("rst_cell_handle", if0.cell_handle, 8'd0);
        chk("rst_cell_meta",  if0.cell_metadata, 8'd0);
        chk("rst_cmd_ready2", 8'(if2.cmd_ready), 8'd1);

        // LOOKUP hit, RED_LAT=0: response at cycle 5 with the phase-1 capture
        if0.cmd_op = 3'd0; if0.cmd_handle = 8'h10; if0.cmd_index = 8'h20; if0.cmd_value = 8'h30;
        if0.cmd_metadata = 8'h40; if0.cmd_is_metadata = 1'b1; if0.cmd_valid = 1'b1;
        tick();
        if0.cmd_valid = 1'b0; if0.cmd_handle = 8'hFF;
        chk("lk_c1_sel",    if0.cell_selector, 8'h01);
        chk("lk_c1_ready",  8'(if0.cmd_ready), 8'd0);
        chk("lk_c1_busy",   8'(busy0), 8'd1);
        chk("lk_handle",    if0.cell_handle, 8'h10);
        chk("lk_index",     if0.cell_index, 8'h20);
        chk("lk_value",     if0.cell_value, 8'h30);
        chk("lk_is_meta",   8'(if0.cell_is_metadata), 8'd1);
        chk("lk_c1_meta",   if0.cell_metadata, 8'h40);
        set_red0(1'b1, 8'h11, 8'h2A);
        tick();
        chk("lk_c2_sel",    if0.cell_selector, 8'h01);
        tick();
        chk("lk_c3_sel",    if0.cell_selector, 8'h07);
        chk("lk_c3_meta",   if0.cell_metadata, 8'h2A);
        chk("lk_c3_wr",     8'(if0.cell_will_write), 8'd0);
        set_red0(1'b1, 8'h55, 8'h3C);
        tick();
        chk("lk_c4_rvalid", 8'(if0.resp_valid), 8'd0);
        tick();
        chk("lk_c5_rvalid", 8'(if0.resp_valid), 8'd1);
        chk("lk_status",    8'(if0.resp_status), 8'd0);
        chk("lk_rvalue",    if0.resp_value, 8'h55);
        chk("lk_rctx",      if0.resp_context, 8'h3C);
        tick();
        chk("lk_c6_rvalid", 8'(if0.resp_valid), 8'd0);
        chk("lk_c6_ready",  8'(if0.cmd_ready), 8'd1);

        // LOOKUP miss: value/context forced to zero at cycle 3
        set_red0(1'b0, 8'h99, 8'h88);
        if0.cmd_op = 3'd0; if0.cmd_valid = 1'b1;
        tick();
        if0.cmd_valid = 1'b0;
        tick();
        tick();
        chk("miss_rvalid", 8'(if0.resp_valid), 8'd1);
        chk("miss_status", 8'(if0.resp_status), 8'b10);
        chk("miss_rvalue", if0.resp_value, 8'd0);
        chk("miss_rctx",   if0.resp_context, 8'd0);
        tick();

        // UPDATE with no free cell: FULL at cycle 3, never a write
        set_red0(1'b0, 8'h00, 8'h00);
        if0.cmd_op = 3'd1; if0.cmd_valid = 1'b1;
        tick();
        if0.cmd_valid = 1'b0;
        wr_seen = if0.cell_will_write;
        chk("full_c1_sel", if0.cell_selector, 8'h05);
        tick();
        wr_seen = wr_seen | if0.cell_will_write;
        chk("full_c2_rvalid", 8'(if0.resp_valid), 8'd0);
        tick();
        wr_seen = wr_seen | if0.cell_will_write;
        chk("full_c3_rvalid", 8'(if0.resp_valid), 8'd1);
        chk("full_status",    8'(if0.resp_status), 8'b01);
        chk("full_no_write",  8'(wr_seen), 8'd0);
        tick();

        // UPDATE success, RED_LAT=2: phases of 4 cycles, response at cycle 13, then backpressure
        if2.red_bool = 1'b1; if2.red_value = 8'h77; if2.red_context = 8'h5A; if2.resp_ready = 1'b0;
        if2.cmd_op = 3'd1; if2.cmd_metadata = 8'h12; if2.cmd_valid = 1'b1;
        tick();
        if2.cmd_valid = 1'b0;
        wr_cnt = 0; wr_cyc = 0;
        for (int c = 1; c <= 13; c++) begin
            if (if2.cell_will_write) begin wr_cnt++; wr_cyc = c; end
            if (c == 1)  chk("up_c1_sel",  if2.cell_selector, 8'h05);
            if (c == 4)  chk("up_c4_meta", if2.cell_metadata, 8'h12);
            if (c == 5)  chk("up_c5_sel",  if2.cell_selector, 8'h00);
            if (c == 5)  chk("up_c5_meta", if2.cell_metadata, 8'h5A);
            if (c == 9)  chk("up_c9_sel",  if2.cell_selector, 8'h06);
            if (c == 12) chk("up_c12_rvalid", 8'(if2.resp_valid), 8'd0);
            if (c == 13) chk("up_c13_rvalid", 8'(if2.resp_valid), 8'd1);
            if (c < 13) tick();
        end
        chk("up_wr_count", 8'(wr_cnt), 8'd1);
        chk("up_wr_cycle", 8'(wr_cyc), 8'd5);
        chk("up_status",   8'(if2.resp_status), 8'd0);
        chk("up_rvalue",   if2.resp_value, 8'h77);
        chk("up_rctx",     if2.resp_context, 8'h5A);
        if2.red_value = 8'hEE; if2.red_context = 8'hDD;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_rvalid", 8'(if2.resp_valid), 8'd1);
            chk("bp_rvalue", if2.resp_value, 8'h77);
            chk("bp_rctx",   if2.resp_context, 8'h5A);
            chk("bp_ready",  8'(if2.cmd_ready), 8'd0);
        end
        if2.resp_ready = 1'b1;
        tick();
        chk("bp_rel_ready",  8'(if2.cmd_ready), 8'd1);
        chk("bp_rel_rvalid", 8'(if2.resp_valid), 8'd0);
        chk("bp_rel_busy",   8'(busy2), 8'd0);

        // ENCODE: single read phase, response at cycle 3
        set_red0(1'b1, 8'h9C, 8'h0F);
        if0.cmd_op = 3'd2; if0.cmd_valid = 1'b1;
        tick();
        if0.cmd_valid = 1'b0;
        chk("enc_c1_sel", if0.cell_selector, 8'h02);
        chk("enc_c1_wr",  8'(if0.cell_will_write), 8'd0);
        tick();
        tick();
        chk("enc_rvalid", 8'(if0.resp_valid), 8'd1);
        chk("enc_rvalue", if0.resp_value, 8'h9C);
        chk("enc_rctx",   if0.resp_context, 8'h0F);
        tick();

        // CONGRUE: two write phases, response at cycle 5
        set_red0(1'b1, 8'hE1, 8'hB4);
        if0.cmd_op = 3'd3; if0.cmd_valid = 1'b1;
        tick();
        if0.cmd_valid = 1'b0;
        chk("cg_c1_sel", if0.cell_selector, 8'h03);
        chk("cg_c1_wr",  8'(if0.cell_will_write), 8'd1);
        tick();
        chk("cg_c2_wr",  8'(if0.cell_will_write), 8'd0);
        chk("cg_c2_sel", if0.cell_selector, 8'h01);
        tick();
        chk("cg_c3_sel", if0.cell_selector, 8'h04);
        chk("cg_c3_wr",  8'(if0.cell_will_write), 8'd1);
        tick();
        tick();
        chk("cg_rvalid", 8'(if0.resp_valid), 8'd1);
        chk("cg_rvalue", if0.resp_value, 8'hE1);
        tick();

        // Illegal op: BADOP at cycle 1, no phase issued
        if0.cmd_op = 3'b110; if0.cmd_valid = 1'b1;
        tick();
        if0.cmd_valid = 1'b0;
        chk("bad_rvalid", 8'(if0.resp_valid), 8'd1);
        chk("bad_status", 8'(if0.resp_status), 8'b11);
        chk("bad_rvalue", if0.resp_value, 8'd0);
        chk("bad_rctx",   if0.resp_context, 8'd0);
        chk("bad_sel",    if0.cell_selector, 8'h01);
        chk("bad_wr",     8'(if0.cell_will_write), 8'd0);
        tick();
        chk("bad_after_rvalid", 8'(if0.resp_valid), 8'd0);
        chk("bad_after_ready",  8'(if0.cmd_ready), 8'd1);

        // Reset during phase-0 ISSUE of a CONGRUE: abandoned, write drops at the reset edge
        if0.cmd_op = 3'd3; if0.cmd_valid = 1'b1;
        tick();
        if0.cmd_valid = 1'b0;
        chk("rm_c1_wr", 8'(if0.cell_will_write), 8'd1);
        rst_n = 1'b0;
        tick();
        chk("rm_rst_wr",     8'(if0.cell_will_write), 8'd0);
        chk("rm_rst_rvalid", 8'(if0.resp_valid), 8'd0);
        chk("rm_rst_busy",   8'(busy0), 8'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rm_post_rvalid", 8'(if0.resp_valid), 8'd0);
            chk("rm_post_wr",     8'(if0.cell_will_write), 8'd0);
        end
        chk("rm_post_sel",   if0.cell_selector, 8'h01);
        chk("rm_post_ready", 8'(if0.cmd_ready), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
